// File: rtl/dds_phase_gen.sv
// dds_phase_gen: DDS phase accumulator with wrap-synchronised frequency commits
// Ports:
//   Fg_CLK     system clock
//   RESET      asynchronous active-high reset
//   Address    frequency setting, FTW = Address << FTW_SHIFT
//   FreqChng   one-cycle strobe marking a new Address
//   Enable     1 = accumulate, 0 = hold
//   Phase      registered truncated phase word
//   PhaseValid Phase is a fresh accumulated sample
//   Wrap       accumulator overflowed on this update
//   Pending    a captured FTW awaits commit
// Optional feature: define PHASE_DITHER_EN to add LFSR dither below the truncation point.
module dds_phase_gen #(
  parameter int ACC_W       = 32,
  parameter int FTW_IN_W    = 12,
  parameter int FTW_SHIFT   = 8,
  parameter int PHASE_OUT_W = 10
) (
  input  logic                   Fg_CLK,
  input  logic                   RESET,
  input  logic [FTW_IN_W-1:0]    Address,
  input  logic                   FreqChng,
  input  logic                   Enable,
  output logic [PHASE_OUT_W-1:0] Phase,
  output logic                   PhaseValid,
  output logic                   Wrap,
  output logic                   Pending
);
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  state_t state;
  logic [ACC_W-1:0] acc, active_ftw, pend_ftw, ftw, sum, acc_nxt;
  logic [PHASE_OUT_W-1:0] phase_src;
  logic carry, acc_en, commit, go_idle;
  assign ftw = ACC_W'(Address) << FTW_SHIFT;
  assign acc_en = (state != IDLE) && Enable;
  assign {carry, sum} = {1'b0, acc} + {1'b0, active_ftw};
  // A pending FTW only takes effect on an accumulator wrap, keeping phase continuous.
  assign commit = (state == PEND) && acc_en && carry;
  assign go_idle = commit && (pend_ftw == '0);
  assign acc_nxt = go_idle ? '0 : sum;
  assign Pending = (state == PEND);
`ifdef PHASE_DITHER_EN
  localparam int LOW_W = ACC_W - PHASE_OUT_W;
  localparam int D = (LOW_W < 16) ? LOW_W : 16;
  logic [15:0] lfsr;
  logic [ACC_W-1:0] dith;
  assign dith = acc_nxt + ACC_W'(lfsr[D-1:0]);
  assign phase_src = dith[ACC_W-1 -: PHASE_OUT_W];
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  always_ff @(posedge Fg_CLK or posedge RESET)
    if (RESET) lfsr <= 16'hACE1;
    else if (acc_en) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
`else
  assign phase_src = acc_nxt[ACC_W-1 -: PHASE_OUT_W];
`endif
  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      acc        <= '0;
      active_ftw <= '0;
      pend_ftw   <= '0;
      Phase      <= '0;
      PhaseValid <= 1'b0;
      Wrap       <= 1'b0;
    end else begin
      PhaseValid <= acc_en;
      Wrap       <= acc_en && carry;
      if (acc_en) begin
        acc   <= acc_nxt;
        Phase <= phase_src;
      end
      case (state)
        IDLE: if (FreqChng && Address != '0) begin
          active_ftw <= ftw;
          state      <= RUN;
        end
        RUN: if (FreqChng) begin
          pend_ftw <= ftw;
          state    <= PEND;
        end
        PEND: if (commit) begin
          active_ftw <= pend_ftw;
          if (go_idle) state <= IDLE;
          else if (FreqChng) pend_ftw <= ftw;
          else state <= RUN;
        end else if (FreqChng) pend_ftw <= ftw;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dds_phase_gen.sv
// tb_dds_phase_gen: randomized self-checking bench for dds_phase_gen against an arithmetic model
module tb_dds_phase_gen;
  logic Fg_CLK_tb = 1'b0;
  logic RESET = 1'b1;
  logic FreqChng = 1'b0;
  logic Enable = 1'b0;
  logic [11:0] Address = '0;
  logic [9:0] Phase;
  logic PhaseValid, Wrap, Pending;
  int n_cmp = 0;
  int n_bad = 0;
  longint m_acc, m_act, m_pnd;
  bit m_run, m_pf;
  logic [9:0] e_phase;
  logic e_pv, e_wrap;
  always #5 Fg_CLK_tb = ~Fg_CLK_tb;
  dds_phase_gen dut (
    .Fg_CLK(Fg_CLK_tb), .RESET(RESET), .Address(Address), .FreqChng(FreqChng),
    .Enable(Enable), .Phase(Phase), .PhaseValid(PhaseValid), .Wrap(Wrap), .Pending(Pending)
  );
  function automatic void model_reset();
    m_acc = 0; m_act = 0; m_pnd = 0; m_run = 0; m_pf = 0;
    e_phase = '0; e_pv = 0; e_wrap = 0;
  endfunction
  // Phase is the top 10 bits of a 32-bit accumulator; a tuning word applies only after a wrap.
  function automatic void model_step();
    longint f, s;
    f = longint'(Address) * 256;
    e_wrap = 0;
    e_pv = m_run && Enable;
    if (!m_run) begin
      if (FreqChng && Address != 0) begin m_act = f; m_run = 1; end
    end else begin
      if (Enable) begin
        s = m_acc + m_act;
        e_wrap = (s >= 64'h1_0000_0000);
        m_acc = s % 64'h1_0000_0000;
      end
      if (m_pf && e_wrap) begin
        m_act = m_pnd;
        if (m_pnd == 0) begin m_acc = 0; m_run = 0; m_pf = 0; end
        else if (FreqChng) m_pnd = f;
        else m_pf = 0;
      end else if (FreqChng) begin
        m_pnd = f; m_pf = 1;
      end
      if (Enable) e_phase = m_acc[31:22];
    end
  endfunction
  function automatic bit wrap_next();
    return m_run && Enable && (m_acc + m_act >= 64'h1_0000_0000);
  endfunction
  task automatic tick();
    @(posedge Fg_CLK_tb);
    if (RESET) model_reset(); else model_step();
    #1;
  endtask
  task automatic pulse(input logic [11:0] a);
    Address = a; FreqChng = 1; tick(); FreqChng = 0;
  endtask
  task automatic test_reset();
    bit bad = 0;
    bit nz = 0;
    tick(); tick();
    n_cmp++;
    if ({Phase, PhaseValid, Wrap, Pending} !== 13'd0) begin
      n_bad++; $display("FAIL reset_init got %h/%b/%b/%b want 0", Phase, PhaseValid, Wrap, Pending);
    end
    RESET = 0; Enable = 1;
    pulse(12'h800);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!bad) begin
        n_cmp++;
        if ({Phase, PhaseValid, Wrap, Pending} !== {e_phase, e_pv, e_wrap, m_pf}) begin
          bad = 1; n_bad++;
          $display("FAIL reset_prerun cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", i, Phase, PhaseValid, Wrap, Pending, e_phase, e_pv, e_wrap, m_pf);
        end
      end
    end
    #3 RESET = 1;
    #1;
    n_cmp++;
    if ({Phase, PhaseValid, Wrap, Pending} !== 13'd0) begin
      n_bad++; $display("FAIL reset_async got %h/%b/%b/%b want 0", Phase, PhaseValid, Wrap, Pending);
    end
    tick();
    RESET = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({Phase, PhaseValid, Wrap, Pending} !== 13'd0) nz = 1;
      if (!bad) begin
        n_cmp++;
        if ({Phase, PhaseValid, Wrap, Pending} !== {e_phase, e_pv, e_wrap, m_pf}) begin
          bad = 1; n_bad++;
          $display("FAIL reset_quiet cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", i, Phase, PhaseValid, Wrap, Pending, e_phase, e_pv, e_wrap, m_pf);
        end
      end
    end
    n_cmp++;
    if (nz) begin n_bad++; $display("FAIL reset_hold nonzero output seen want all 0 for 100 cycles"); end
  endtask
  task automatic test_single_tone();
    bit bad = 0;
    int upd = 0;
    int last = 0;
    int nw = 0;
    pulse(12'h800);
    n_cmp++;
    if ({PhaseValid, Pending} !== 2'b00) begin
      n_bad++; $display("FAIL tone_start got pv=%b pend=%b want 0/0", PhaseValid, Pending);
    end
    for (int i = 0; i < 16400 && nw < 2; i++) begin
      tick(); upd++;
      if (!bad) begin
        n_cmp++;
        if ({Phase, PhaseValid, Wrap, Pending} !== {e_phase, e_pv, e_wrap, m_pf}) begin
          bad = 1; n_bad++;
          $display("FAIL tone cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", i, Phase, PhaseValid, Wrap, Pending, e_phase, e_pv, e_wrap, m_pf);
        end
      end
      if (upd == 1) begin
        n_cmp++;
        if ({Phase, PhaseValid} !== {10'd0, 1'b1}) begin
          n_bad++; $display("FAIL tone_first got %h/%b want 000/1", Phase, PhaseValid);
        end
      end
      if (Wrap) begin
        nw++; n_cmp++;
        if (upd - last != 8192 || Phase !== 10'd0) begin
          n_bad++; $display("FAIL tone_wrap period %0d phase %h want 8192 000", upd - last, Phase);
        end
        last = upd;
      end
    end
    n_cmp++;
    if (nw != 2) begin n_bad++; $display("FAIL tone_wrap_count got %0d want 2", nw); end
  endtask
  task automatic test_pending();
    bit bad = 0;
    bit seen = 0;
    int k = 0;
    for (int i = 0; i < 100; i++) tick();
    pulse(12'h400);
    n_cmp++;
    if (Pending !== 1'b1) begin n_bad++; $display("FAIL pend_set got %b want 1", Pending); end
    for (int i = 0; i < 9000 && !seen; i++) begin
      tick();
      if (Wrap) seen = 1;
      if (!bad) begin
        n_cmp++;
        if ({Phase, PhaseValid, Wrap, Pending} !== {e_phase, e_pv, e_wrap, m_pf}) begin
          bad = 1; n_bad++;
          $display("FAIL pend cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", i, Phase, PhaseValid, Wrap, Pending, e_phase, e_pv, e_wrap, m_pf);
        end
      end
    end
    n_cmp++;
    if (!seen || Pending !== 1'b0) begin n_bad++; $display("FAIL pend_commit wrap=%b pend=%b want 1/0", seen, Pending); end
    seen = 0;
    for (int i = 0; i < 16500 && !seen; i++) begin
      tick(); k++;
      if (Wrap) seen = 1;
      if (!bad) begin
        n_cmp++;
        if ({Phase, PhaseValid, Wrap, Pending} !== {e_phase, e_pv, e_wrap, m_pf}) begin
          bad = 1; n_bad++;
          $display("FAIL pend_new cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", i, Phase, PhaseValid, Wrap, Pending, e_phase, e_pv, e_wrap, m_pf);
        end
      end
    end
    n_cmp++;
    if (!seen || k != 16384) begin n_bad++; $display("FAIL pend_period got %0d want 16384", k); end
  endtask
  task automatic test_back_to_back();
    bit bad = 0;
    bit seen = 0;
    logic [11:0] a0, a1, a2;
    a0 = 12'($urandom_range(12'hFFF, 12'h800));
    a1 = 12'($urandom_range(12'hFFF, 12'h800));
    a2 = 12'($urandom_range(12'hFFF, 12'h800));
    RESET = 1; tick(); RESET = 0;
    pulse(a0);
    repeat (5) tick();
    pulse(a1);
    n_cmp++;
    if (Pending !== 1'b1) begin n_bad++; $display("FAIL b2b_pend got %b want 1", Pending); end
    for (int i = 0; i < 9000 && !(m_pf && wrap_next()); i++) begin
      tick();
      if (!bad) begin
        n_cmp++;
        if ({Phase, PhaseValid, Wrap, Pending} !== {e_phase, e_pv, e_wrap, m_pf}) begin
          bad = 1; n_bad++;
          $display("FAIL b2b cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", i, Phase, PhaseValid, Wrap, Pending, e_phase, e_pv, e_wrap, m_pf);
        end
      end
    end
    n_cmp++;
    if (!wrap_next()) begin n_bad++; $display("FAIL b2b_timeout no wrap within budget"); end
    pulse(a2);
    n_cmp++;
    if ({Wrap, Pending} !== 2'b11 || Phase !== e_phase) begin
      n_bad++; $display("FAIL b2b_coincide got wrap=%b pend=%b ph=%h want 1/1/%h", Wrap, Pending, Phase, e_phase);
    end
    for (int i = 0; i < 9000 && !seen; i++) begin
      tick();
      if (Wrap) seen = 1;
      if (!bad) begin
        n_cmp++;
        if ({Phase, PhaseValid, Wrap, Pending} !== {e_phase, e_pv, e_wrap, m_pf}) begin
          bad = 1; n_bad++;
          $display("FAIL b2b_tail cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", i, Phase, PhaseValid, Wrap, Pending, e_phase, e_pv, e_wrap, m_pf);
        end
      end
    end
    n_cmp++;
    if (!seen || Pending !== 1'b0) begin n_bad++; $display("FAIL b2b_final wrap=%b pend=%b want 1/0", seen, Pending); end
  endtask
  task automatic test_zero_ftw();
    bit bad = 0;
    bit seen = 0;
    pulse(12'h000);
    n_cmp++;
    if (Pending !== 1'b1) begin n_bad++; $display("FAIL zero_pend got %b want 1", Pending); end
    for (int i = 0; i < 9000 && !seen; i++) begin
      tick();
      if (Wrap) seen = 1;
      if (!bad) begin
        n_cmp++;
        if ({Phase, PhaseValid, Wrap, Pending} !== {e_phase, e_pv, e_wrap, m_pf}) begin
          bad = 1; n_bad++;
          $display("FAIL zero cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", i, Phase, PhaseValid, Wrap, Pending, e_phase, e_pv, e_wrap, m_pf);
        end
      end
    end
    n_cmp++;
    if (!seen || Pending !== 1'b0 || Phase !== 10'd0) begin
      n_bad++; $display("FAIL zero_wrap wrap=%b pend=%b ph=%h want 1/0/000", seen, Pending, Phase);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bad) begin
        n_cmp++;
        if ({Phase, PhaseValid, Wrap, Pending} !== 13'd0) begin
          bad = 1; n_bad++;
          $display("FAIL zero_idle cyc %0d got %h/%b/%b/%b want 0", i, Phase, PhaseValid, Wrap, Pending);
        end
      end
    end
    pulse(12'h800);
    tick();
    n_cmp++;
    if ({Phase, PhaseValid} !== {10'd0, 1'b1}) begin
      n_bad++; $display("FAIL zero_restart got %h/%b want 000/1", Phase, PhaseValid);
    end
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!bad) begin
        n_cmp++;
        if ({Phase, PhaseValid, Wrap, Pending} !== {e_phase, e_pv, e_wrap, m_pf}) begin
          bad = 1; n_bad++;
          $display("FAIL zero_rerun cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", i, Phase, PhaseValid, Wrap, Pending, e_phase, e_pv, e_wrap, m_pf);
        end
      end
    end
  endtask
  task automatic test_enable_hold();
    bit bad = 0;
    bit seen = 0;
    bit moved = 0;
    logic [9:0] hold;
    pulse(12'($urandom_range(12'hFFF, 12'h800)));
    repeat (10) tick();
    hold = Phase;
    Enable = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (Phase !== hold || PhaseValid !== 1'b0 || Wrap !== 1'b0 || Pending !== 1'b1) moved = 1;
      if (!bad) begin
        n_cmp++;
        if ({Phase, PhaseValid, Wrap, Pending} !== {e_phase, e_pv, e_wrap, m_pf}) begin
          bad = 1; n_bad++;
          $display("FAIL hold cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", i, Phase, PhaseValid, Wrap, Pending, e_phase, e_pv, e_wrap, m_pf);
        end
      end
    end
    n_cmp++;
    if (moved) begin n_bad++; $display("FAIL hold_frozen outputs changed while disabled, want ph=%h pv=0 pend=1", hold); end
    Enable = 1;
    for (int i = 0; i < 9000 && !seen; i++) begin
      tick();
      if (Wrap) seen = 1;
      if (!bad) begin
        n_cmp++;
        if ({Phase, PhaseValid, Wrap, Pending} !== {e_phase, e_pv, e_wrap, m_pf}) begin
          bad = 1; n_bad++;
          $display("FAIL hold_resume cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", i, Phase, PhaseValid, Wrap, Pending, e_phase, e_pv, e_wrap, m_pf);
        end
      end
    end
    n_cmp++;
    if (!seen || Pending !== 1'b0) begin n_bad++; $display("FAIL hold_commit wrap=%b pend=%b want 1/0", seen, Pending); end
    for (int i = 0; i < 3000; i++) begin
      Enable = ($urandom_range(0, 3) != 0);
      FreqChng = ($urandom_range(0, 99) < 2);
      Address = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom_range(12'hFFF, 12'h400));
      tick();
      if (!bad) begin
        n_cmp++;
        if ({Phase, PhaseValid, Wrap, Pending} !== {e_phase, e_pv, e_wrap, m_pf}) begin
          bad = 1; n_bad++;
          $display("FAIL soak cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", i, Phase, PhaseValid, Wrap, Pending, e_phase, e_pv, e_wrap, m_pf);
        end
      end
    end
    FreqChng = 0;
  endtask
  initial begin
    model_reset();
    test_reset();
    test_single_tone();
    test_pending();
    test_back_to_back();
    test_zero_ftw();
    test_enable_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
